rf_write_arbiter: RTL and testbench

//  Shares the register file's single write port between the in-order WB stage and a multi-cycle aux unit (div/late load).

---
 rtl/rf_write_arbiter.sv | 160 ++++++++++++++++
 tb/tb_rf_write_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single write port between the in-order WB stage
// and a multi-cycle aux unit (divider / late load). Aux results are queued in
// a small FIFO. A per-register pending count records which destinations still
// have an aux write in flight. That count drives the ID-stage RAW hazard
// flags, and it also drives the WAW ordering rule against WB writes.
//
// Handshake (aux side): a transfer happens at a clk edge where
// aux_valid && aux_ready. aux_ready depends only on FIFO occupancy (!full);
// it does not look at aux_valid, and it ignores a pop in the same cycle.
// The WB side has no ready. When pipe_stall is high, the WB write was refused
// and the pipeline presents it again on the next cycle.
module rf_write_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_wr,
  input  logic [4:0]    pipe_dst,
  input  logic [DW-1:0] pipe_data,
  input  logic          aux_valid,
  output logic          aux_ready,
  input  logic [4:0]    aux_dst,
  input  logic [DW-1:0] aux_data,
  output logic          pipe_stall,
  output logic          rf_we,
  output logic [4:0]    rf_dst,
  output logic [DW-1:0] rf_data,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  output logic          rs_busy,
  output logic          rt_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT);

  // Aux FIFO storage. Each pointer has one extra MSB, so full and empty can
  // be told apart.
  logic [4:0]    dst_mem  [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  // Number of queued aux writes per architectural register.
  logic [PW-1:0] pending [32];

  // Number of consecutive cycles the FIFO head has been denied the port.
  logic [WW-1:0] wait_cnt;

  logic          fifo_empty;
  logic          fifo_full;
  logic [4:0]    head_dst;
  logic [DW-1:0] head_data;
  logic          push;
  logic          pop;
  logic          pipe_valid;
  logic          waw_hit;
  logic          force_pop;

  // FIFO status, head view, and the qualified request terms.
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    head_dst   = dst_mem[rd_ptr[AW-1:0]];
    head_data  = data_mem[rd_ptr[AW-1:0]];
    aux_ready  = !fifo_full;
    // An aux result for r0 is accepted but never stored.
    push       = aux_valid && !fifo_full && (aux_dst != 5'd0);
    // A WB write to r0 is dropped. It neither writes nor stalls.
    pipe_valid = pipe_wr && (pipe_dst != 5'd0);
    waw_hit    = pipe_valid && (pending[pipe_dst] != '0);
    force_pop  = !fifo_empty && ((wait_cnt == WAIT_LIMIT) || waw_hit);
  end

  // Write-port grant: a forced head wins, then WB, then an idle-slot drain.
  always_comb begin
    pop        = 1'b0;
    rf_we      = 1'b0;
    rf_dst     = 5'd0;
    rf_data    = '0;
    pipe_stall = 1'b0;
    if (force_pop) begin
      pop        = 1'b1;
      rf_we      = 1'b1;
      rf_dst     = head_dst;
      rf_data    = head_data;
      pipe_stall = pipe_valid;
    end else if (pipe_valid) begin
      rf_we      = 1'b1;
      rf_dst     = pipe_dst;
      rf_data    = pipe_data;
    end else if (!fifo_empty) begin
      pop        = 1'b1;
      rf_we      = 1'b1;
      rf_dst     = head_dst;
      rf_data    = head_data;
    end
  end

  // RAW hazard flags. An entry popped this cycle still reads busy, because
  // the RF write-through covers the following cycle.
  always_comb begin
    rs_busy = (pending[id_rs] != '0);
    rt_busy = (pending[id_rt] != '0);
  end

  // FIFO pointers. The storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage write on push.
  always_ff @(posedge clk) begin
    if (push) begin
      dst_mem[wr_ptr[AW-1:0]]  <= aux_dst;
      data_mem[wr_ptr[AW-1:0]] <= aux_data;
    end
  end

  // Pending scoreboard. A push and a pop of the same register in one cycle
  // cancel out. r0 is held at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) pending[r] <= '0;
    end else begin
      pending[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if ((push && aux_dst == 5'(r)) && !(pop && head_dst == 5'(r)))
          pending[r] <= pending[r] + PW'(1);
        else if ((pop && head_dst == 5'(r)) && !(push && aux_dst == 5'(r)))
          pending[r] <= pending[r] - PW'(1);
      end
    end
  end

  // Head starvation counter. It restarts whenever the head moves or the FIFO
  // is empty, and it saturates at the forcing threshold.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if (pop || fifo_empty) begin
      wait_cnt <= '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt <= wait_cnt + WW'(1);
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
// Directed bench for rf_write_arbiter. A reference model made of a queue and
// an age counter predicts every output on every cycle. Literal expectations
// at key points pin down the model itself.
module tb_rf_write_arbiter;

  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 8;
  localparam int DW       = 32;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          pipe_wr;
  logic [4:0]    pipe_dst;
  logic [DW-1:0] pipe_data;
  logic          aux_valid;
  logic          aux_ready;
  logic [4:0]    aux_dst;
  logic [DW-1:0] aux_data;
  logic          pipe_stall;
  logic          rf_we;
  logic [4:0]    rf_dst;
  logic [DW-1:0] rf_data;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic          rs_busy;
  logic          rt_busy;

  always #5 clk = ~clk;

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .pipe_wr(pipe_wr), .pipe_dst(pipe_dst), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready), .aux_dst(aux_dst), .aux_data(aux_data),
    .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data),
    .id_rs(id_rs), .id_rt(id_rt), .rs_busy(rs_busy), .rt_busy(rt_busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Compare one observed value against its expectation.
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [5+DW-1:0] exp_q[$];   // queued aux writes, {dst, data}, oldest first
  int              m_age;      // cycles the current head has been refused
  bit              model_ok = 0;
  logic [DW-1:0]   rf_obs [32];

  function automatic int pend_of(input logic [4:0] r);
    int n = 0;
    foreach (exp_q[k]) if (exp_q[k][5+DW-1:DW] == r) n++;
    return n;
  endfunction

  // Compare process: predict this cycle's outputs, compare them, then advance
  // the model over the upcoming clock edge.
  always @(negedge clk) begin
    bit            m_empty, m_full, pv, frc, e_we, e_stall, e_pop;
    logic [4:0]    e_dst;
    logic [DW-1:0] e_data;
    m_empty = (exp_q.size() == 0);
    m_full  = (exp_q.size() == DEPTH);
    pv      = pipe_wr && (pipe_dst != 0);
    frc     = !m_empty && ((m_age >= MAX_WAIT) || (pv && pend_of(pipe_dst) != 0));
    e_we = 0; e_stall = 0; e_pop = 0; e_dst = '0; e_data = '0;
    if (frc || (!pv && !m_empty)) begin
      e_pop = 1; e_we = 1;
      e_dst = exp_q[0][5+DW-1:DW]; e_data = exp_q[0][DW-1:0];
      e_stall = frc && pv;
    end else if (pv) begin
      e_we = 1; e_dst = pipe_dst; e_data = pipe_data;
    end
    if (model_ok) begin
      chk("aux_ready",  64'(aux_ready),  64'(!m_full));
      chk("rf_we",      64'(rf_we),      64'(e_we));
      chk("rf_dst",     64'(rf_dst),     64'(e_dst));
      chk("rf_data",    64'(rf_data),    64'(e_data));
      chk("pipe_stall", 64'(pipe_stall), 64'(e_stall));
      chk("rs_busy",    64'(rs_busy),    64'(pend_of(id_rs) != 0));
      chk("rt_busy",    64'(rt_busy),    64'(pend_of(id_rt) != 0));
    end
    if (rf_we) rf_obs[rf_dst] = rf_data;
    if (rst) begin
      exp_q.delete();
      m_age    = 0;
      model_ok = 1;
    end else begin
      if (e_pop || m_empty) m_age = 0;
      else if (m_age < MAX_WAIT) m_age++;
      if (e_pop) void'(exp_q.pop_front());
      if (aux_valid && !m_full && aux_dst != 0) exp_q.push_back({aux_dst, aux_data});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic wr, input logic [4:0] d, input logic [DW-1:0] v);
    pipe_wr = wr; pipe_dst = d; pipe_data = v;
  endtask

  task automatic set_aux(input logic vld, input logic [4:0] d, input logic [DW-1:0] v);
    aux_valid = vld; aux_dst = d; aux_data = v;
  endtask

  task automatic idle();
    set_pipe(0, 5'd0, '0);
    set_aux(0, 5'd0, '0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1; id_rs = 5'd0; id_rt = 5'd0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // 1: idle after reset, then a zero-latency WB write
    @(negedge clk);
    chk("t1_idle_we",    64'(rf_we),      64'd0);
    chk("t1_idle_ready", 64'(aux_ready),  64'd1);
    chk("t1_idle_stall", 64'(pipe_stall), 64'd0);
    chk("t1_idle_busy",  64'(rs_busy | rt_busy), 64'd0);
    cyc();
    set_pipe(1, 5'd5, 32'h11);
    @(negedge clk);
    chk("t1_wb_we",   64'(rf_we),   64'd1);
    chk("t1_wb_dst",  64'(rf_dst),  64'd5);
    chk("t1_wb_data", 64'(rf_data), 64'h11);
    cyc();

    // 2: single aux push drains one cycle later; rs busy only in between
    idle(); id_rs = 5'd3;
    set_aux(1, 5'd3, 32'hA);
    @(negedge clk);
    chk("t2_push_we",   64'(rf_we),   64'd0);
    chk("t2_push_busy", 64'(rs_busy), 64'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("t2_pop_dst",  64'(rf_dst),  64'd3);
    chk("t2_pop_data", 64'(rf_data), 64'hA);
    chk("t2_pop_busy", 64'(rs_busy), 64'd1);
    cyc();
    @(negedge clk);
    chk("t2_after_busy", 64'(rs_busy), 64'd0);
    chk("t2_after_we",   64'(rf_we),   64'd0);
    cyc();

    // 3: fill the FIFO under constant WB traffic; the head is forced at the age limit
    id_rs = 5'd20; id_rt = 5'd23;
    for (int i = 0; i < 40; i++) begin
      set_pipe(1, 5'(10 + (i % 4)), 32'h100 + 32'(i));
      set_aux(i < 4, 5'(20 + i), 32'h200 + 32'(i));
      @(negedge clk);
      if (i == 4) chk("t3_full_ready", 64'(aux_ready), 64'd0);
      if (i == 9) begin
        chk("t3_force_stall", 64'(pipe_stall), 64'd1);
        chk("t3_force_dst",   64'(rf_dst),     64'd20);
        chk("t3_force_data",  64'(rf_data),    64'h200);
      end
      cyc();
    end
    idle();
    repeat (6) cyc();
    chk("t3_order_last", 64'(rf_obs[23]), 64'h203);

    // 4: WAW - the pending aux write to r7 goes ahead of the WB write to r7
    id_rs = 5'd7; id_rt = 5'd0;
    set_pipe(1, 5'd1, 32'h1);
    set_aux(1, 5'd7, 32'h77);
    cyc();
    set_aux(0, 5'd0, '0);
    set_pipe(1, 5'd7, 32'h7777);
    @(negedge clk);
    chk("t4_stall",     64'(pipe_stall), 64'd1);
    chk("t4_aux_dst",   64'(rf_dst),     64'd7);
    chk("t4_aux_data",  64'(rf_data),    64'h77);
    chk("t4_aux_busy",  64'(rs_busy),    64'd1);
    cyc();
    @(negedge clk);
    chk("t4_wb_stall", 64'(pipe_stall), 64'd0);
    chk("t4_wb_data",  64'(rf_data),    64'h7777);
    chk("t4_wb_busy",  64'(rs_busy),    64'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("t4_rf7_final", 64'(rf_obs[7]), 64'h7777);
    cyc();

    // 5: r0 writes from either side are discarded
    id_rs = 5'd0;
    set_pipe(1, 5'd0, 32'h66);
    set_aux(1, 5'd0, 32'h55);
    @(negedge clk);
    chk("t5_we",    64'(rf_we),      64'd0);
    chk("t5_stall", 64'(pipe_stall), 64'd0);
    chk("t5_busy",  64'(rs_busy),    64'd0);
    cyc();
    idle();
    @(negedge clk);
    chk("t5_next_we", 64'(rf_we), 64'd0);
    cyc();

    // 6: reset with three entries queued loses them
    id_rs = 5'd24; id_rt = 5'd25;
    for (int i = 0; i < 3; i++) begin
      set_pipe(1, 5'd2, 32'h300 + 32'(i));
      set_aux(1, 5'(24 + i), 32'h400 + 32'(i));
      cyc();
    end
    idle();
    rst = 1;
    cyc();
    rst = 0;
    @(negedge clk);
    chk("t6_we",    64'(rf_we),     64'd0);
    chk("t6_rs",    64'(rs_busy),   64'd0);
    chk("t6_rt",    64'(rt_busy),   64'd0);
    chk("t6_ready", 64'(aux_ready), 64'd1);
    cyc();
    repeat (3) cyc();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
